// File: rtl/fp_cmul_pkg.sv
// Shared types and constants for the FP32 complex-multiply array.
//   fp32_t      : IEEE-754 single-precision word
//   FP_SIGN_BIT : bit index of the sign
//   CMUL_LAT    : cycles from operands sampled to result on the core outputs
package fp_cmul_pkg;
  typedef logic [31:0] fp32_t;
  localparam int FP_SIGN_BIT = 31;
  localparam int CMUL_LAT    = 8;
endpackage

// File: rtl/FP_Complex_MULT.sv
// Fully pipelined FP32 complex multiplier: q = a*c - b*d, r = a*d + b*c.
// Stage 1 holds the four products, stage 2 the sums, remaining stages delay
// the result so the total latency is exactly LAT (>= 2). Never stalls.
//   clk    in  clock
//   areset in  async reset, active high
//   a,b    in  real / imaginary part of X
//   c,d    in  real / imaginary part of Y
//   q,r    out real / imaginary part of the product
// Denormals flush to zero, rounding is to nearest even.
module FP_Complex_MULT
  import fp_cmul_pkg::*;
#(
  parameter int LAT = CMUL_LAT
) (
  input  logic  clk,
  input  logic  areset,
  input  fp32_t a,
  input  fp32_t b,
  input  fp32_t c,
  input  fp32_t d,
  output fp32_t q,
  output fp32_t r
);

  function automatic fp32_t fp_mul(fp32_t x, fp32_t y);
    logic        s, g, st;
    logic [47:0] p;
    logic [23:0] m;
    int          e;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'b0};
    p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
    end
    m = m + 24'(g & (st | m[0]));
    if (m[23]) e = e + 1;            // rounded up to 2.0, fraction already 0
    if (e <= 0)   return {s, 31'b0};
    if (e >= 255) return {s, 8'hFF, 23'b0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic fp32_t fp_add(fp32_t x, fp32_t y);
    fp32_t       big, sml;
    logic [26:0] mb, ms;             // hidden bit, 23 fraction, guard/round/sticky
    logic [27:0] s;
    logic [23:0] m;
    logic        st;
    int          e, sh;
    if (x[30:23] == 8'd0) return y;
    if (y[30:23] == 8'd0) return x;
    if (x[30:0] >= y[30:0]) begin big = x; sml = y; end
    else                    begin big = y; sml = x; end
    e  = int'(big[30:23]);
    sh = e - int'(sml[30:23]);
    mb = {1'b1, big[22:0], 3'b0};
    ms = {1'b1, sml[22:0], 3'b0};
    if (sh > 26) ms = 27'd1;
    else if (sh > 0) begin
      st = |(ms & ((27'd1 << sh) - 27'd1));
      ms = (ms >> sh) | {26'd0, st};
    end
    if (big[31] == sml[31]) begin
      s = {1'b0, mb} + {1'b0, ms};
      if (s[27]) begin s = {1'b0, s[27:2], s[1] | s[0]}; e = e + 1; end
    end else begin
      s = {1'b0, mb} - {1'b0, ms};
      if (s == 28'd0) return 32'h0;  // exact cancellation gives +0
      for (int i = 0; i < 26; i++)
        if (!s[26]) begin s = s << 1; e = e - 1; end
    end
    m = {1'b0, s[25:3]} + 24'(s[2] & (s[1] | s[0] | s[3]));
    if (m[23]) e = e + 1;
    if (e <= 0)   return {big[31], 31'b0};
    if (e >= 255) return {big[31], 8'hFF, 23'b0};
    return {big[31], e[7:0], m[22:0]};
  endfunction

  fp32_t                 ac_q, bd_q, ad_q, bc_q;
  logic [LAT-2:0][31:0]  q_dly_q, r_dly_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ac_q <= '0; bd_q <= '0; ad_q <= '0; bc_q <= '0;
      q_dly_q <= '0; r_dly_q <= '0;
    end else begin
      ac_q <= fp_mul(a, c);
      bd_q <= fp_mul(b, d);
      ad_q <= fp_mul(a, d);
      bc_q <= fp_mul(b, c);
      q_dly_q[0] <= fp_add(ac_q, {~bd_q[FP_SIGN_BIT], bd_q[FP_SIGN_BIT-1:0]});
      r_dly_q[0] <= fp_add(ad_q, bc_q);
      for (int i = 1; i < LAT - 1; i++) begin
        q_dly_q[i] <= q_dly_q[i-1];
        r_dly_q[i] <= r_dly_q[i-1];
      end
    end
  end

  assign q = q_dly_q[LAT-2];
  assign r = r_dly_q[LAT-2];

endmodule

// File: rtl/cmul_result_fifo.sv
// Synchronous FIFO holding completed array results until the consumer pops.
//   clk_i, rst_ni : clock, synchronous active-low reset (empties the FIFO)
//   wr_en_i/wr_data_i : push (caller guarantees not full)
//   rd_en_i       : pop (caller guarantees not empty)
//   rd_data_o     : head entry, valid while empty_o=0
//   empty_o       : no entries
module cmul_result_fifo #(
  parameter int DEPTH = 10,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i)
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr_en_i) - CW'(rd_en_i);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (cnt_q == '0);
endmodule

// File: rtl/fp_complex_mult_array.sv
// LANES parallel FP32 complex multipliers with valid/ready flow control.
// Cores free-run; a LAT-deep valid/tag/mask shift register marks real data,
// and a credit counter sized to the result FIFO keeps it from overflowing,
// so the cores never need to stall.
//   clk, reset       : clock, synchronous active-low reset
//   in_valid/in_ready: input handshake; a,b,c,d operands, conj, lane_en, in_tag
//   out_valid/out_ready: output handshake; q,r results, out_tag
//   busy             : anything accepted and not yet popped
module fp_complex_mult_array
  import fp_cmul_pkg::*;
#(
  parameter int LANES = 16,
  parameter int LAT   = CMUL_LAT,
  parameter int DEPTH = LAT + 2,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0][31:0] a,
  input  logic [LANES-1:0][31:0] b,
  input  logic [LANES-1:0][31:0] c,
  input  logic [LANES-1:0][31:0] d,
  input  logic                   conj,
  input  logic [LANES-1:0]       lane_en,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0][31:0] q,
  output logic [LANES-1:0][31:0] r,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < LAT + 2) begin : g_depth_chk
    $error("fp_complex_mult_array: DEPTH must be >= LAT+2");
  end

  typedef struct packed {
    logic [TAG_W-1:0]       tag;
    logic [LANES-1:0][31:0] r;
    logic [LANES-1:0][31:0] q;
  } res_t;

  logic                       accept, pop, fifo_empty, in_ready_q;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [LAT:1]               vld_pipe_q;   // index k = k cycles after accept
  logic [LAT:1][TAG_W-1:0]    tag_pipe_q;
  logic [LAT:1][LANES-1:0]    mask_pipe_q;
  logic [LANES-1:0][31:0]     core_q, core_r, q_m, r_m;
  res_t                       wr_res, rd_res;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp32_t d_eff;
    assign d_eff = {d[i][FP_SIGN_BIT] ^ conj, d[i][FP_SIGN_BIT-1:0]};
    FP_Complex_MULT #(.LAT(LAT)) u_core (
      .clk    (clk),
      .areset (~reset),
      .a      (a[i]),
      .b      (b[i]),
      .c      (c[i]),
      .d      (d_eff),
      .q      (core_q[i]),
      .r      (core_r[i])
    );
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      q_m[i] = mask_pipe_q[LAT][i] ? core_q[i] : 32'h0;
      r_m[i] = mask_pipe_q[LAT][i] ? core_r[i] : 32'h0;
    end
  end

  always_comb begin
    wr_res.tag = tag_pipe_q[LAT];
    wr_res.q   = q_m;
    wr_res.r   = r_m;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe_q  <= '0;
      tag_pipe_q  <= '0;
      mask_pipe_q <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      vld_pipe_q[1]  <= accept;
      tag_pipe_q[1]  <= in_tag;
      mask_pipe_q[1] <= lane_en;
      for (int k = 2; k <= LAT; k++) begin
        vld_pipe_q[k]  <= vld_pipe_q[k-1];
        tag_pipe_q[k]  <= tag_pipe_q[k-1];
        mask_pipe_q[k] <= mask_pipe_q[k-1];
      end
      cnt_q      <= cnt_d;
      // registered copy of (cnt < DEPTH), held low through reset
      in_ready_q <= (cnt_d < CW'(DEPTH));
    end
  end

  cmul_result_fifo #(.DEPTH(DEPTH), .W($bits(res_t))) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wr_en_i   (vld_pipe_q[LAT]),
    .wr_data_i (wr_res),
    .rd_en_i   (pop),
    .rd_data_o (rd_res),
    .empty_o   (fifo_empty)
  );

  // FIFO storage is not reset; gate the data so idle outputs read as zero
  assign out_valid = ~fifo_empty;
  assign q         = out_valid ? rd_res.q   : '0;
  assign r         = out_valid ? rd_res.r   : '0;
  assign out_tag   = out_valid ? rd_res.tag : '0;
  assign in_ready  = in_ready_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_fp_complex_mult_array.sv
module tb_fp_complex_mult_array;
  localparam int LANES = 16, LAT = 8, DEPTH = LAT + 2, TAG_W = 8;

  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, conj = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [LANES-1:0][31:0] a = '0, b = '0, c = '0, d = '0, q, r;
  logic [LANES-1:0] lane_en = '1;
  logic [TAG_W-1:0] in_tag = '0, out_tag;

  always #5 clk = ~clk;

  fp_complex_mult_array #(.LANES(LANES), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .conj(conj), .lane_en(lane_en), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r), .out_tag(out_tag),
    .busy(busy)
  );

  typedef struct { logic [7:0] tag; logic [511:0] q; logic [511:0] r; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  int oa[LANES], ob[LANES], oc[LANES], od[LANES];

  task automatic chk(input string nm, input logic [511:0] obs, input logic [511:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", nm, obs, expv);
    end
  endtask

  // exact int -> fp32 for the small integers used as operands and results
  function automatic logic [31:0] i2f(int v);
    logic [31:0] m;
    logic        s;
    int          p;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    m = m << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int rnd_op();
    int v = int'($urandom_range(1, 7));
    return ($urandom_range(0, 1) == 1) ? -v : v;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < LANES; i++) begin
      a[i] = i2f(oa[i]); b[i] = i2f(ob[i]); c[i] = i2f(oc[i]); d[i] = i2f(od[i]);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < LANES; i++) begin
      oa[i] = rnd_op(); ob[i] = rnd_op(); oc[i] = rnd_op(); od[i] = rnd_op();
    end
    drive_ops();
  endtask

  task automatic push_exp();
    exp_t e;
    int   dd;
    e.tag = in_tag; e.q = '0; e.r = '0;
    for (int i = 0; i < LANES; i++)
      if (lane_en[i]) begin
        dd = conj ? -od[i] : od[i];
        e.q[i*32 +: 32] = i2f(oa[i]*oc[i] - ob[i]*dd);
        e.r[i*32 +: 32] = i2f(oa[i]*dd + ob[i]*oc[i]);
      end
    sb.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    logic pend;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    pend = (sb.size() != 0) || busy;
    chk("drain", pend, 1'b0);
    next_cyc();
  endtask

  task automatic one_shot(input logic [7:0] tg, input logic cj, input logic [15:0] en,
                          input logic [31:0] eq0, er0, eq8, er8);
    in_tag = tg; conj = cj; lane_en = en; drive_ops(); in_valid = 1'b1;
    @(negedge clk); chk("os_in_ready", in_ready, 1'b1); push_exp();
    next_cyc(); in_valid = 1'b0;
    repeat (LAT - 1) next_cyc();
    @(negedge clk); chk("os_early_valid", out_valid, 1'b0);
    next_cyc();
    @(negedge clk);
    chk("os_valid", out_valid, 1'b1);
    chk("os_q0", q[0], eq0); chk("os_r0", r[0], er0);
    chk("os_q8", q[8], eq8); chk("os_r8", r[8], er8);
    chk("os_tag", out_tag, tg);
    wait_drain();
  endtask

  // scoreboard + hold-stability monitor
  logic stall_q = 1'b0;
  logic [7:0] h_tag;
  logic [511:0] h_q, h_r;
  always @(negedge clk) begin
    if (!reset) stall_q <= 1'b0;
    else begin
      if (stall_q) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_tag", out_tag, h_tag);
        chk("hold_q", q, h_q);
        chk("hold_r", r, h_r);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_tag", out_tag, e.tag);
          chk("out_q", q, e.q);
          chk("out_r", r, e.r);
        end
      end
      stall_q <= out_valid && !out_ready;
      h_tag <= out_tag; h_q <= q; h_r <= r;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    logic expv;
    // reset state
    repeat (3) next_cyc();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_q", q, '0);
    chk("rst_r", r, '0);
    chk("rst_tag", out_tag, '0);
    chk("rst_busy", busy, 1'b0);
    next_cyc(); reset = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    next_cyc();

    // single transactions with latency and known constants
    for (int i = 0; i < LANES; i++) begin oa[i] = 1; ob[i] = 2; oc[i] = 3; od[i] = 4; end
    one_shot(8'h5A, 1'b0, 16'hFFFF, 32'hC0A00000, 32'h41200000, 32'hC0A00000, 32'h41200000);
    one_shot(8'hA5, 1'b1, 16'hFFFF, 32'h41300000, 32'h40000000, 32'h41300000, 32'h40000000);
    for (int i = 0; i < LANES; i++) begin oa[i] = 1; ob[i] = 1; oc[i] = 1; od[i] = 1; end
    one_shot(8'h33, 1'b0, 16'h00FF, 32'h0, 32'h40000000, 32'h0, 32'h0);

    // random stream with random backpressure
    n = 0; rand_ops(); in_tag = 8'h80; conj = 1'b0; lane_en = 16'(($urandom));
    in_valid = 1'b1;
    for (int k = 0; k < 200 && n < 24; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        push_exp(); n++;
        next_cyc();
        rand_ops(); in_tag = 8'h80 + 8'(n); conj = 1'($urandom_range(0, 1));
        lane_en = 16'($urandom);
      end else next_cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("rand_accepts", n, 24);
    wait_drain();

    // fill to DEPTH with output stalled, then release
    out_ready = 1'b0; acc = 0; in_tag = 8'd0; rand_ops(); conj = 1'b0; lane_en = '1;
    in_valid = 1'b1;
    for (int k = 0; k < 3*DEPTH; k++) begin
      @(negedge clk);
      if (in_ready) begin push_exp(); acc++; end
      next_cyc();
      in_tag = 8'(acc);
      if (in_ready) rand_ops();
    end
    @(negedge clk);
    chk("stall_accepts", acc, DEPTH);
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_busy", busy, 1'b1);
    next_cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    chk("ready_after_pop", in_ready, 1'b1);
    wait_drain();

    // 200 back-to-back with out_ready held high
    for (int cyc = 0; cyc <= LAT + 201; cyc++) begin
      if (cyc < 200) begin
        rand_ops(); in_valid = 1'b1; in_tag = 8'(cyc);
        conj = 1'($urandom_range(0, 1)); lane_en = 16'($urandom);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (cyc < 200) begin
        chk("b2b_in_ready", in_ready, 1'b1);
        if (in_ready) push_exp();
      end
      expv = (cyc >= LAT + 1) && (cyc <= LAT + 200);
      chk("b2b_out_valid", out_valid, expv);
      next_cyc();
    end
    wait_drain();

    // reset in the middle of traffic
    for (int k = 0; k < 5; k++) begin
      rand_ops(); in_valid = 1'b1; in_tag = 8'(8'h40 + k); lane_en = '1; conj = 1'b0;
      @(negedge clk);
      if (in_ready) push_exp();
      next_cyc();
    end
    in_valid = 1'b0; reset = 1'b0; sb.delete();
    next_cyc(); reset = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      chk("post_mid_rst_out_valid", out_valid, 1'b0);
      next_cyc();
    end
    rand_ops(); in_tag = 8'h77; in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_send_ready", in_ready, 1'b1);
    if (in_ready) push_exp();
    next_cyc(); in_valid = 1'b0;
    wait_drain();

    chk("sb_empty_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_complex_mult_array.md
FP_COMPLEX_MULT_ARRAY -- requirements
Module: fp_complex_mult_array

Interface
REQ-001 Parameter LANES, default 16: number of parallel complex-multiply lanes (1..64).
REQ-002 Parameter LAT, default fp_cmul_pkg::CMUL_LAT (8): fixed latency of one FP_Complex_MULT core in cycles.
REQ-003 Parameter DEPTH, default LAT+2: result buffer depth in entries; DEPTH >= LAT+2 is enforced by elaboration assertion.
REQ-004 Parameter TAG_W, default 8: width of the sideband tag carried with each transaction.
REQ-005 Port list, one line per port:
  clk       in   1    sole clock, rising edge
  reset     in   1    synchronous, active-low reset
  in_valid  in   1    input transaction present
  in_ready  out  1    block accepts input this cycle
  a         in   32xLANES  real part of operand X, IEEE-754 single
  b         in   32xLANES  imaginary part of X
  c         in   32xLANES  real part of Y
  d         in   32xLANES  imaginary part of Y
  conj      in   1    1: multiply X by conj(Y)
  lane_en   in   LANES  per-lane enable
  in_tag    in   TAG_W  sideband
  out_valid out  1    result present
  out_ready in   1    consumer accepts result
  q         out  32xLANES  real result
  r         out  32xLANES  imaginary result
  out_tag   out  TAG_W  tag of the result
  busy      out  1    any transaction in flight or buffered

Function
REQ-006 Accept = in_valid && in_ready; pop = out_valid && out_ready.
REQ-007 Per lane: q = a*c - b*d and r = a*d + b*c, computed by FP_Complex_MULT; when conj=1, the sign bit of d is inverted before the core.
REQ-008 A lane with lane_en=0 outputs q=r=32'h0 for that transaction; lane_en, conj and in_tag are captured at accept.
REQ-009 Cores run continuously without stall; a LAT-deep valid/tag/mask shift register marks real data.
REQ-010 A core result whose shift-register valid is set is written into the result FIFO at cycle LAT after accept, becomes visible at cycle LAT+1, and is held stable until popped.
REQ-011 Credit counter cnt (0..DEPTH) = transactions in the pipe plus FIFO entries; +1 on accept, -1 on pop, unchanged when both occur.
REQ-012 in_ready = (cnt < DEPTH), registered-equivalent and independent of in_valid and out_ready in the same cycle.
REQ-013 With out_ready held at 1, the block sustains one accept per cycle indefinitely.
REQ-014 Results leave in strict acceptance order; none is dropped or duplicated.
REQ-015 A transaction presented while in_ready=0 is not accepted; the producer holds it.
REQ-016 out_valid, q, r and out_tag do not change while out_valid=1 and out_ready=0.
REQ-017 busy = (cnt != 0).

Reset
REQ-018 While reset=0 at a clk edge: cnt=0, FIFO emptied, valid shift register cleared, out_valid=0, q=r=0, out_tag=0, in_ready=0.
REQ-019 In the first cycle after reset returns to 1, in_ready=1 and busy=0.
REQ-020 Reset asserted mid-operation discards all in-flight and buffered transactions; stale core pipeline contents never appear at the output.
REQ-021 The core's areset is driven by ~reset.

Structure
REQ-022 Package fp_cmul_pkg holds the fp32_t typedef, FP_SIGN_BIT=31, and the CMUL_LAT constant.
REQ-023 Lanes are generate-instanced from the existing FP_Complex_MULT.
REQ-024 One new sub-module, cmul_result_fifo: synchronous FIFO of DEPTH entries, each (2*32*LANES + TAG_W) bits wide.

Verification
REQ-025 Lane 0 gets a=1.0, b=2.0, c=3.0, d=4.0 with conj=0 and tag=8'h5A -> after LAT+1 cycles, q=32'hC0A00000 (-5), r=32'h41200000 (10), out_tag=8'h5A.
REQ-026 Same operands with conj=1 -> q=32'h41300000 (11), r=32'h40000000 (2).
REQ-027 lane_en=16'h00FF with every lane's operands set to 1+1j -> lanes 0-7 give q=0, r=32'h40000000; lanes 8-15 give q=r=0.
REQ-028 out_ready=0 with in_valid held at 1 -> exactly DEPTH accepts, then in_ready=0; out_ready then set to 1 -> DEPTH results in tag order 0..DEPTH-1, and in_ready=1 the cycle after the first pop.
REQ-029 200 back-to-back transactions with out_ready=1 -> in_ready never drops and out_valid is continuous from cycle LAT+1 to LAT+200.
REQ-030 Reset=0 for 1 cycle after 5 transactions are accepted -> no out_valid afterwards, and a transaction sent after reset is the first result seen.
